// File: rtl/opb_register_simulink2ppc_status_pkg.sv
// Shared constants and types for the OPB software-register blocks.
// Bit positions use OPB numbering: bit 0 is the MSB, bit 31 the LSB.
package opb_reg_pkg;

    localparam logic [1:0] IDX_DATA    = 2'd0;
    localparam logic [1:0] IDX_STATUS  = 2'd1;
    localparam logic [1:0] IDX_CONTROL = 2'd2;

    localparam int NEW_BIT    = 31;
    localparam int OVF_LSB    = 30;
    localparam int FREEZE_BIT = 31;

    typedef struct packed {
        logic [0:31] dbus;
        logic        xfer_ack;
    } opb_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } ack_state_t;

    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] high);
        return (addr >= base) && (addr <= high);
    endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_status_if.sv
// OPB slave-side signal bundle; the master drives OPB_*, the slave drives Sl_*.
interface opb_register_simulink2ppc_status_if;

    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

endinterface

// File: rtl/opb_register_simulink2ppc_status_opb_slave_ack.sv
// Address decode plus a registered single-cycle acknowledge; the request fields
// are latched when a transfer is accepted so the register action can use them on the ack cycle.
module opb_slave_ack
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0108E900,
    parameter logic [31:0] C_HIGHADDR = 32'h0108E9FF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        select,
    input  logic [0:31] abus,
    input  logic [0:3]  be,
    input  logic [0:31] dbus,
    input  logic        rnw,
    output logic        accept,
    output logic        ack,
    output logic [1:0]  word_idx,
    output logic        rnw_q,
    output logic [0:3]  be_q,
    output logic [0:31] dbus_q
);

    // state   | meaning
    // ST_IDLE | waiting for a decoded select
    // ST_ACK  | acknowledge high for this single cycle
    // ST_HOLD | already acked; select must drop before the next transfer

    ack_state_t state, state_next;
    logic       hit;

    assign hit    = select && in_window(abus, C_BASEADDR, C_HIGHADDR);
    assign accept = (state == ST_IDLE) && hit;
    assign ack    = (state == ST_ACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (hit) state_next = ST_ACK;
            ST_ACK:  state_next = hit ? ST_HOLD : ST_IDLE;
            ST_HOLD: if (!hit) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= '0;
            rnw_q    <= 1'b0;
            be_q     <= '0;
            dbus_q   <= '0;
        end else if (accept) begin
            word_idx <= abus[28:29];
            rnw_q    <= rnw;
            be_q     <= be;
            dbus_q   <= dbus;
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc_status.sv
// Status register read by the PowerPC: snapshots user_data_in on user_valid and
// exposes a new-data flag, a saturating overrun counter and a software freeze.
module opb_register_simulink2ppc_status
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0108E900,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108E9FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter int          C_CNT_WIDTH  = 8
) (
    input  logic                                     OPB_Clk,
    input  logic                                     OPB_Rst_n,
    opb_register_simulink2ppc_status_if.slave        opb,
    input  logic [31:0]                              user_data_in,
    input  logic                                     user_valid,
    output logic                                     user_new_flag
);

    localparam logic FAMILY_KNOWN = (C_FAMILY == "virtex5");

    logic [0:C_OPB_AWIDTH-1] addr;
    logic [0:C_OPB_DWIDTH-1] rd_d, rd_q;
    logic                    accept, ack, rnw_q;
    logic [1:0]              word_idx;
    logic [0:3]              be_q;
    logic [0:31]             dbus_q;

    logic [31:0]             snapshot_q, snapshot_d;
    logic                    new_q, new_d;
    logic                    freeze_q, freeze_d;
    logic [C_CNT_WIDTH-1:0]  ovf_q, ovf_d;
    logic                    capture, data_rd, status_clr, ctrl_wr, overrun;
    opb_resp_t               resp;
    logic                    unused_ok;

    assign addr = opb.OPB_ABus;

    opb_slave_ack #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_ack (
        .clk      (OPB_Clk),
        .rst_n    (OPB_Rst_n),
        .select   (opb.OPB_select),
        .abus     (addr),
        .be       (opb.OPB_BE),
        .dbus     (opb.OPB_DBus),
        .rnw      (opb.OPB_RNW),
        .accept   (accept),
        .ack      (ack),
        .word_idx (word_idx),
        .rnw_q    (rnw_q),
        .be_q     (be_q),
        .dbus_q   (dbus_q)
    );

    assign capture    = user_valid && !freeze_q;
    assign data_rd    = ack && rnw_q && (word_idx == IDX_DATA);
    assign status_clr = ack && !rnw_q && (word_idx == IDX_STATUS) && be_q[3] && dbus_q[NEW_BIT];
    assign ctrl_wr    = ack && !rnw_q && (word_idx == IDX_CONTROL) && be_q[3];
    assign overrun    = capture && new_q && !data_rd;

    always_comb begin
        snapshot_d = capture ? user_data_in : snapshot_q;
        new_d      = new_q;
        if (capture)      new_d = 1'b1;
        else if (data_rd) new_d = 1'b0;
        ovf_d = ovf_q;
        if (status_clr)                  ovf_d = overrun ? C_CNT_WIDTH'(1) : '0;
        else if (overrun && ovf_q != '1) ovf_d = ovf_q + 1'b1;
        freeze_d = ctrl_wr ? dbus_q[FREEZE_BIT] : freeze_q;
    end

    // Read data is registered on accept from the values the registers hold
    // during the ack cycle, so it matches what the ack-cycle action sees.
    always_comb begin
        rd_d = '0;
        if (accept && opb.OPB_RNW) begin
            case (addr[28:29])
                IDX_DATA:    rd_d = snapshot_d;
                IDX_STATUS: begin
                    rd_d[NEW_BIT] = new_d;
                    rd_d[OVF_LSB - C_CNT_WIDTH + 1 +: C_CNT_WIDTH] = ovf_d;
                end
                IDX_CONTROL: rd_d[FREEZE_BIT] = freeze_d;
                default:     rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            snapshot_q <= '0;
            new_q      <= 1'b0;
            ovf_q      <= '0;
            freeze_q   <= 1'b0;
            rd_q       <= '0;
        end else begin
            snapshot_q <= snapshot_d;
            new_q      <= new_d;
            ovf_q      <= ovf_d;
            freeze_q   <= freeze_d;
            rd_q       <= rd_d;
        end
    end

    assign resp = '{dbus: rd_q, xfer_ack: ack};

    assign opb.Sl_DBus    = resp.dbus;
    assign opb.Sl_xferAck = resp.xfer_ack;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;
    assign user_new_flag  = new_q;

    assign unused_ok = ^{opb.OPB_seqAddr, be_q[0:2], dbus_q[0:30], FAMILY_KNOWN};

endmodule

// File: tb/tb_opb_register_simulink2ppc_status.sv
// Bench for the simulink2ppc status register: table of bus/user operations with
// read data checked through an expectation queue, plus hand-written corner sequences.
module tb_opb_register_simulink2ppc_status;

    localparam logic [31:0] BASE  = 32'h0108E900;
    localparam logic [31:0] A_DAT = BASE;
    localparam logic [31:0] A_STA = BASE + 32'h4;
    localparam logic [31:0] A_CTL = BASE + 32'h8;
    localparam logic [31:0] A_R3  = BASE + 32'hC;

    localparam logic [1:0] OP_PU = 2'd0;
    localparam logic [1:0] OP_RD = 2'd1;
    localparam logic [1:0] OP_WR = 2'd2;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [0:3]  be;
        logic [31:0] expd;
        logic        exp_ack;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] user_data_in = '0;
    logic        user_valid = 1'b0;
    logic        user_new_flag;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    vec_t        vecs[$];

    opb_register_simulink2ppc_status_if bus ();

    opb_register_simulink2ppc_status dut (
        .OPB_Clk       (clk),
        .OPB_Rst_n     (rst_n),
        .opb           (bus),
        .user_data_in  (user_data_in),
        .user_valid    (user_valid),
        .user_new_flag (user_new_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    // Read data is popped from the expectation queue on every read ack; all other cycles must be 0.
    always @(negedge clk) begin
        if (bus.Sl_xferAck && bus.OPB_RNW) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with data %h, expected no ack", bus.Sl_DBus);
            end else begin
                chk(name_q.pop_front(), bus.Sl_DBus, exp_q.pop_front());
            end
        end else begin
            chk("dbus_idle", bus.Sl_DBus, 32'h0);
        end
    end

    task automatic add(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [0:3] be, input logic [31:0] expd, input logic exp_ack);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.be = be; v.expd = expd; v.exp_ack = exp_ack;
        vecs.push_back(v);
    endtask

    task automatic pulse(input logic [31:0] d);
        @(posedge clk); #1;
        user_valid = 1'b1;
        user_data_in = d;
        @(posedge clk); #1;
        user_valid = 1'b0;
    endtask

    // One transfer; optionally strobes user_valid during the ack cycle.
    task automatic bus_op(input string name, input logic [31:0] addr, input logic rnw,
                          input logic [31:0] wdata, input logic [0:3] be, input logic [31:0] expd,
                          input logic exp_ack, input logic coinc, input logic [31:0] cdata);
        logic got;
        int   lat;
        @(posedge clk); #1;
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = rnw;
        bus.OPB_DBus   = wdata;
        bus.OPB_BE     = be;
        bus.OPB_select = 1'b1;
        if (rnw && exp_ack) begin
            exp_q.push_back(expd);
            name_q.push_back(name);
        end
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (bus.Sl_xferAck) begin
                got = 1'b1;
                lat = i;
                if (coinc) begin
                    user_valid = 1'b1;
                    user_data_in = cdata;
                end
            end
        end
        if (exp_ack) begin
            if (got) chk({name, "_latency"}, 32'(lat), 32'd1);
            else chk({name, "_ack_timeout"}, 32'(got), 32'd1);
        end else begin
            chk({name, "_no_ack"}, 32'(got), 32'd0);
        end
        @(posedge clk); #1;
        bus.OPB_select = 1'b0;
        user_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] expd);
        bus_op(name, addr, 1'b1, 32'h0, 4'hF, expd, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] d);
        bus_op(name, addr, 1'b0, d, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        int acks;
        bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
        bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;

        @(negedge clk);
        chk("reset_ack", 32'(bus.Sl_xferAck), 32'd0);
        chk("reset_new_flag", 32'(user_new_flag), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        add(OP_RD, A_STA, 0, 4'hF, 32'h0, 1);
        add(OP_PU, 0, 32'hDEADBEEF, 4'hF, 0, 0);
        add(OP_RD, A_STA, 0, 4'hF, 32'h1, 1);
        add(OP_RD, A_DAT, 0, 4'hF, 32'hDEADBEEF, 1);
        add(OP_RD, A_STA, 0, 4'hF, 32'h0, 1);
        add(OP_PU, 0, 32'h1, 4'hF, 0, 0);
        add(OP_PU, 0, 32'h2, 4'hF, 0, 0);
        add(OP_PU, 0, 32'h3, 4'hF, 0, 0);
        add(OP_RD, A_STA, 0, 4'hF, 32'h5, 1);
        add(OP_RD, A_DAT, 0, 4'hF, 32'h3, 1);
        add(OP_RD, A_STA, 0, 4'hF, 32'h4, 1);
        add(OP_PU, 0, 32'h11, 4'hF, 0, 0);
        add(OP_RD, A_STA, 0, 4'hF, 32'h5, 1);
        add(OP_WR, A_STA, 32'hFFFFFFFE, 4'hF, 0, 1);
        add(OP_RD, A_STA, 0, 4'hF, 32'h5, 1);
        add(OP_WR, A_STA, 32'h1, 4'hF, 0, 1);
        add(OP_RD, A_STA, 0, 4'hF, 32'h1, 1);
        add(OP_RD, A_DAT, 0, 4'hF, 32'h11, 1);
        add(OP_PU, 0, 32'h22, 4'hF, 0, 0);
        add(OP_WR, A_CTL, 32'h1, 4'hF, 0, 1);
        add(OP_RD, A_CTL, 0, 4'hF, 32'h1, 1);
        add(OP_PU, 0, 32'h12345678, 4'hF, 0, 0);
        add(OP_RD, A_STA, 0, 4'hF, 32'h1, 1);
        add(OP_RD, A_DAT, 0, 4'hF, 32'h22, 1);
        add(OP_WR, A_CTL, 32'h0, 4'hF, 0, 1);
        add(OP_RD, A_CTL, 0, 4'hF, 32'h0, 1);
        add(OP_WR, A_CTL, 32'h1, 4'b1110, 0, 1);
        add(OP_RD, A_CTL, 0, 4'hF, 32'h0, 1);
        add(OP_PU, 0, 32'h12345678, 4'hF, 0, 0);
        add(OP_RD, A_STA, 0, 4'hF, 32'h1, 1);
        add(OP_RD, A_DAT, 0, 4'hF, 32'h12345678, 1);
        add(OP_WR, A_DAT, 32'hFFFFFFFF, 4'hF, 0, 1);
        add(OP_RD, A_DAT, 0, 4'hF, 32'h12345678, 1);
        add(OP_RD, A_R3, 0, 4'hF, 32'h0, 1);
        add(OP_WR, A_R3, 32'hFFFFFFFF, 4'hF, 0, 1);
        add(OP_RD, A_STA, 0, 4'hF, 32'h0, 1);
        add(OP_RD, A_CTL, 0, 4'hF, 32'h0, 1);
        add(OP_RD, BASE + 32'hFF, 0, 4'hF, 32'h0, 1);
        add(OP_RD, 32'h0108EA00, 0, 4'hF, 32'h0, 0);
        add(OP_RD, 32'h0108E8FC, 0, 4'hF, 32'h0, 0);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_PU: pulse(vecs[i].data);
                OP_RD: bus_op($sformatf("vec%0d_rd", i), vecs[i].addr, 1'b1, 32'h0, vecs[i].be,
                              vecs[i].expd, vecs[i].exp_ack, 1'b0, 32'h0);
                default: bus_op($sformatf("vec%0d_wr", i), vecs[i].addr, 1'b0, vecs[i].data, vecs[i].be,
                                32'h0, vecs[i].exp_ack, 1'b0, 32'h0);
            endcase
        end

        // Saturation: 300 back-to-back captures.
        @(posedge clk); #1;
        user_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            user_data_in = 32'h1000 + 32'(i);
            @(posedge clk); #1;
        end
        user_valid = 1'b0;
        chk("sat_new_flag", 32'(user_new_flag), 32'd1);
        rd("sat_status", A_STA, 32'h1FF);
        wr("sat_clear", A_STA, 32'h1);
        rd("sat_status_cleared", A_STA, 32'h1);
        rd("sat_data", A_DAT, 32'h112B);

        // W1C coinciding with an overrun capture leaves ovf at 1.
        pulse(32'hA1);
        pulse(32'hA2);
        bus_op("w1c_coinc", A_STA, 1'b0, 32'h1, 4'hF, 32'h0, 1'b1, 1'b1, 32'hA3);
        rd("w1c_coinc_status", A_STA, 32'h3);
        rd("w1c_coinc_data", A_DAT, 32'hA3);

        // DATA read ack coinciding with a capture.
        wr("coll_clear", A_STA, 32'h1);
        pulse(32'h0BADF00D);
        bus_op("coll_read", A_DAT, 1'b1, 32'h0, 4'hF, 32'h0BADF00D, 1'b1, 1'b1, 32'hA5A5A5A5);
        rd("coll_status", A_STA, 32'h1);
        rd("coll_data", A_DAT, 32'hA5A5A5A5);

        // Freeze write coinciding with a capture: the capture still lands.
        bus_op("frz_coinc", A_CTL, 1'b0, 32'h1, 4'hF, 32'h0, 1'b1, 1'b1, 32'hF00DCAFE);
        rd("frz_coinc_data", A_DAT, 32'hF00DCAFE);
        rd("frz_coinc_ctl", A_CTL, 32'h1);
        wr("frz_off", A_CTL, 32'h0);

        // Select held for 4 cycles gets exactly one ack.
        @(posedge clk); #1;
        bus.OPB_ABus = A_DAT; bus.OPB_RNW = 1'b1; bus.OPB_BE = 4'hF; bus.OPB_select = 1'b1;
        exp_q.push_back(32'hF00DCAFE);
        name_q.push_back("held_data");
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.Sl_xferAck) acks++;
        end
        @(posedge clk); #1;
        bus.OPB_select = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.Sl_xferAck) acks++;
        end
        chk("held_single_ack", 32'(acks), 32'd1);

        // Reset asserted during an ack cycle.
        pulse(32'h77);
        chk("pre_reset_new_flag", 32'(user_new_flag), 32'd1);
        @(posedge clk); #1;
        bus.OPB_ABus = A_DAT; bus.OPB_RNW = 1'b1; bus.OPB_BE = 4'hF; bus.OPB_select = 1'b1;
        exp_q.push_back(32'h77);
        name_q.push_back("rst_mid_data");
        acks = 0;
        for (int i = 0; i < 4 && acks == 0; i++) begin
            @(negedge clk);
            if (bus.Sl_xferAck) acks = 1;
        end
        chk("rst_mid_ack_seen", 32'(acks), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ack", 32'(bus.Sl_xferAck), 32'd0);
        chk("rst_dbus", bus.Sl_DBus, 32'h0);
        chk("rst_new_flag", 32'(user_new_flag), 32'd0);
        bus.OPB_select = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd("post_rst_status", A_STA, 32'h0);
        rd("post_rst_data", A_DAT, 32'h0);
        rd("post_rst_ctl", A_CTL, 32'h0);

        repeat (3) @(posedge clk);
        chk("pending_reads", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc_status.md
Name: opb_register_simulink2ppc_status

Overview:
- OPB slave that carries data in the opposite direction to a ppc2simulink register: user logic writes, and the PowerPC reads.
- Captures `user_data_in` on a user strobe and holds it as a snapshot for software.
- Adds a new-data flag, a saturating overrun counter and a software freeze control.
- Instantiated by per-register wrappers on the OPB bus alongside the other software registers.
- Single clock: user logic runs on `OPB_Clk`.

Parameters:
- C_BASEADDR, 32'h0108E900, first byte address of the decoded window.
- C_HIGHADDR, 32'h0108E9FF, last byte address of the decoded window.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_FAMILY, "virtex5", target family (informational).
- C_CNT_WIDTH, 8, overrun counter width (1..24).

Ports:
- OPB_Clk  in  1  sole clock, shared by the bus side and the user side.
- OPB_Rst_n  in  1  asynchronous active-low reset.
- OPB_ABus  in  [0:31]  bus address, bit 0 is the MSB.
- OPB_BE  in  [0:3]  byte enables.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer in progress.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; 0 whenever `Sl_xferAck` is low.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied to 0.
- user_data_in  in  [31:0]  value to publish.
- user_valid  in  1  capture strobe.
- user_new_flag  out  1  copy of the status new-data bit.

Behaviour:
- Reset:
  - Async assert on `OPB_Rst_n` low, synchronous release.
  - snapshot = 0, new = 0, ovf = 0, freeze = 0.
  - `Sl_xferAck` = 0, `Sl_DBus` = 0, `user_new_flag` = 0.
- Decode:
  - hit = `OPB_select` & (C_BASEADDR <= ABus <= C_HIGHADDR).
  - Word index = `OPB_ABus[28:29]`.
- Acknowledge handshake:
  - `Sl_xferAck` is registered: it rises the cycle after hit & !`Sl_xferAck`, high for exactly 1 cycle.
  - Read/write latency is therefore 1 cycle.
  - A select held across the ack gets no second ack; a new ack needs a fresh hit.
  - If `OPB_select` drops before the ack, the pending ack is still issued (master ignores it).
  - The register action executes on the ack cycle, using the address/data/BE registered at the hit cycle.
- Register map (word index):
  - 0 DATA (RO): snapshot. A read clears new, unless a capture occurs in the same cycle.
  - 1 STATUS:
    - Read: bit 31 = new, bits 30..(31-C_CNT_WIDTH) = ovf, other bits 0.
    - Write with BE[3]=1 and DBus[31]=1: clear ovf (W1C).
  - 2 CONTROL:
    - Read: bit 31 = freeze.
    - Write with BE[3]=1: freeze <= DBus[31].
  - 3: reads 0; writes ignored but acked.
  - Writes to DATA are acked with no effect.
- Capture, each cycle:
  - If `user_valid` & !freeze: snapshot <= `user_data_in`, new <= 1.
  - If new was already 1 and is not being cleared this cycle, ovf increments, saturating at 2^C_CNT_WIDTH-1.
  - If freeze = 1: `user_valid` is ignored entirely — no capture, no flag change, no ovf change.
- Simultaneous events:
  - DATA read ack + capture: the read returns the old snapshot, new stays 1, no ovf increment.
  - STATUS W1C + overrun capture in the same cycle: ovf ends at 1.
  - CONTROL write setting freeze + `user_valid` in the same cycle: the capture still happens, because freeze takes effect the next cycle.
- `Sl_DBus` is registered with `Sl_xferAck` and forced to 0 on all other cycles (wired-OR bus).
- `user_new_flag` equals the registered new bit (no extra latency).

Decomposition:
- Shared package `opb_reg_pkg`:
  - Word index constants: DATA=0, STATUS=1, CONTROL=2.
  - STATUS bit positions: NEW_BIT=31, OVF_LSB.
  - CONTROL bit position: FREEZE_BIT=31.
  - OPB response struct: dbus, xferAck.
- One natural sub-module: `opb_slave_ack`.
  - Contains the address decode, the registered single-cycle ack, and the latched addr/RNW/BE/data.
  - Reused by future OPB register blocks.
- Capture and register logic stay in the top module.

Test Plan:
- Reset: hold `OPB_Rst_n` low mid-transfer → ack, DBus and all registers 0 immediately; after release, reading STATUS returns 0x00000000.
- Capture/read:
  - Pulse `user_valid` with 0xDEADBEEF.
  - Read STATUS → 0x00000001; read DATA → 0xDEADBEEF, ack exactly 1 cycle after select.
  - Read STATUS again → 0x00000000.
- Overrun:
  - 3 `user_valid` pulses without a read → STATUS bit31=1, ovf=2; 300 pulses → ovf saturates at 255.
  - Write STATUS with 0x00000001 → ovf=0, new unchanged.
- Freeze:
  - Write CONTROL 0x1, then pulse `user_valid` with 0x12345678 → DATA keeps its old value, new/ovf unchanged.
  - Write CONTROL 0x0, pulse again → captured.
- Collision: DATA read ack and `user_valid` (0xA5A5A5A5) in the same cycle → read returns the prior value; STATUS then shows new=1, ovf unchanged.
- Bus hygiene:
  - Out-of-range address or offset 0xC → no ack for out-of-range, 0 for 0xC.
  - `OPB_select` held 4 cycles → a single ack.
  - `Sl_DBus` is 0 on all non-ack cycles.
